// File: rtl/pipelined_subtractor.sv
// Segmented, fully pipelined unsigned subtractor: d = (a - b - bin) mod 2^WIDTH.
// The borrow ripples one SEG_W-bit segment per clock. Operand segments are skewed
// to meet their own operation's borrow, and result segments are deskewed so the
// whole difference, borrow-out and zero flag emerge aligned N_SEG cycles later.
module pipelined_subtractor #(
    parameter int WIDTH = 128,
    parameter int SEG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero
);
    // Guarded so a bad SEG_W reaches the elaboration error instead of a divide by zero.
    localparam int N_SEG = (SEG_W < 1) ? 1 : WIDTH / SEG_W;

    if (SEG_W < 1) begin : g_bad_seg_w
        $error("pipelined_subtractor: SEG_W must be at least 1");
    end else if (WIDTH % SEG_W != 0) begin : g_bad_width
        $error("pipelined_subtractor: WIDTH must be a multiple of SEG_W");
    end

    // One segment subtract; MSB of the result is the borrow out of the segment.
    function automatic logic [SEG_W:0] seg_sub(
        input logic [SEG_W-1:0] x,
        input logic [SEG_W-1:0] y,
        input logic             bi
    );
        seg_sub = {1'b0, x} - {1'b0, y} - {{SEG_W{1'b0}}, bi};
    endfunction

    // Deskewed stage results, one slice per segment, all belonging to one operation.
    logic [WIDTH-1:0] seg_aligned;

    for (genvar k = 0; k < N_SEG; k++) begin : g_seg
        logic [SEG_W-1:0] a_in;
        logic [SEG_W-1:0] b_in;
        logic             brw_in;
        logic             zf_in;
        logic             vld_in;
        logic [SEG_W-1:0] diff_d, diff_q;
        logic             brw_d, brw_q;
        logic             zf_d, zf_q;
        logic             vld_d, vld_q;

        if (k == 0) begin : g_head
            // Stage 0 takes its operand slice, bin and in_valid straight from the ports.
            always_comb begin
                a_in   = a[SEG_W-1:0];
                b_in   = b[SEG_W-1:0];
                brw_in = bin;
                zf_in  = 1'b1;
                vld_in = in_valid;
            end
        end else begin : g_body
            logic [SEG_W-1:0] a_sk_d [0:k-1];
            logic [SEG_W-1:0] a_sk_q [0:k-1];
            logic [SEG_W-1:0] b_sk_d [0:k-1];
            logic [SEG_W-1:0] b_sk_q [0:k-1];

            // Skew shift: segment k of the operands waits k cycles for its borrow.
            always_comb begin
                a_sk_d[0] = a[k*SEG_W +: SEG_W];
                b_sk_d[0] = b[k*SEG_W +: SEG_W];
                for (int j = 1; j < k; j++) begin
                    a_sk_d[j] = a_sk_q[j-1];
                    b_sk_d[j] = b_sk_q[j-1];
                end
            end

            // Skew registers.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_sk_q <= '{default: '0};
                    b_sk_q <= '{default: '0};
                end else begin
                    a_sk_q <= a_sk_d;
                    b_sk_q <= b_sk_d;
                end
            end

            // Later stages chain borrow, zero flag and valid from the previous stage.
            always_comb begin
                a_in   = a_sk_q[k-1];
                b_in   = b_sk_q[k-1];
                brw_in = g_seg[k-1].brw_q;
                zf_in  = g_seg[k-1].zf_q;
                vld_in = g_seg[k-1].vld_q;
            end
        end

        // Stage k: subtract this segment and fold its zero test into the running flag.
        always_comb begin
            {brw_d, diff_d} = seg_sub(a_in, b_in, brw_in);
            zf_d            = zf_in & (diff_d == '0);
            vld_d           = vld_in;
        end

        // ---- stage k boundary ----
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                diff_q <= '0;
                brw_q  <= 1'b0;
                zf_q   <= 1'b0;
                vld_q  <= 1'b0;
            end else begin
                diff_q <= diff_d;
                brw_q  <= brw_d;
                zf_q   <= zf_d;
                vld_q  <= vld_d;
            end
        end

        if (k < N_SEG - 1) begin : g_dsk
            localparam int DEPTH = N_SEG - 1 - k;
            logic [SEG_W-1:0] dsk_d [0:DEPTH-1];
            logic [SEG_W-1:0] dsk_q [0:DEPTH-1];

            // Deskew shift: early segments wait for the last segment to resolve.
            always_comb begin
                dsk_d[0] = diff_q;
                for (int j = 1; j < DEPTH; j++) begin
                    dsk_d[j] = dsk_q[j-1];
                end
            end

            // Deskew registers.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dsk_q <= '{default: '0};
                end else begin
                    dsk_q <= dsk_d;
                end
            end

            assign seg_aligned[k*SEG_W +: SEG_W] = dsk_q[DEPTH-1];
        end else begin : g_last
            assign seg_aligned[k*SEG_W +: SEG_W] = diff_q;
        end
    end

    logic [WIDTH-1:0] d_d, d_q;
    logic             bout_d, bout_q;
    logic             zero_d, zero_q;
    logic             out_valid_d, out_valid_q;

    // Output stage gathers the aligned result; keeps ports fully registered.
    always_comb begin
        d_d         = seg_aligned;
        bout_d      = g_seg[N_SEG-1].brw_q;
        zero_d      = g_seg[N_SEG-1].zf_q;
        out_valid_d = g_seg[N_SEG-1].vld_q;
    end

    // ---- output boundary ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q         <= '0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            d_q         <= d_d;
            bout_q      <= bout_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign d         = d_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Bench for pipelined_subtractor at WIDTH=128, SEG_W=16 (latency 8).
module tb_pipelined_subtractor;
    localparam int W   = 128;
    localparam int LAT = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic [W-1:0] d;
    logic         bout;
    logic         zero;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         zero;
        int           issue;
    } exp_t;

    exp_t sb[$];
    bit   vq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    pipelined_subtractor #(.WIDTH(W), .SEG_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .d        (d),
        .bout     (bout),
        .zero     (zero)
    );

    function automatic logic [W-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Drive one cycle; records the reference result (wide subtract) when valid.
    task automatic drive(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi);
        exp_t     e;
        logic [W:0] full;
        in_valid = v;
        a        = aa;
        b        = bb;
        bin      = bi;
        if (rst_n) begin
            full    = {1'b0, aa} - {1'b0, bb} - {{W{1'b0}}, bi};
            e.d     = full[W-1:0];
            e.bout  = full[W];
            e.zero  = (full[W-1:0] == '0);
            e.issue = cyc + 1;
            if (v) sb.push_back(e);
            vq.push_back(v);
        end else begin
            sb.delete();
            vq.delete();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, rnd128(), rnd128(), 1'b1);
        drive(1'b1, rnd128(), rnd128(), 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (d !== '0) begin bad++; $display("FAIL reset_d got=%h want=0", d); end
        total++; if (bout !== 1'b0) begin bad++; $display("FAIL reset_bout got=%b want=0", bout); end
        total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", zero); end
        rst_n = 1'b1;
    endtask

    // Single operation, then idle; checks spec-given constants and the scoreboard.
    task automatic test_vector(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                               input logic bi, input logic [W-1:0] ed, input logic eb, input logic ez);
        exp_t e;
        bit   exp_v;
        for (int i = 0; i < LAT + 2; i++) begin
            if (i == 0) drive(1'b1, aa, bb, bi);
            else        drive(1'b0, rnd128(), rnd128(), 1'($urandom_range(0, 1)));
            exp_v = (vq.size() > LAT) ? vq.pop_front() : 1'b0;
            total++;
            if (out_valid !== exp_v) begin
                bad++; $display("FAIL %s_valid cyc=%0d got=%b want=%b", tag, cyc, out_valid, exp_v);
            end else if (exp_v) begin
                e = sb.pop_front();
                total++;
                if (d !== e.d || bout !== e.bout || zero !== e.zero || cyc - e.issue != LAT) begin
                    bad++; $display("FAIL %s_model got=%h/%b/%b lat=%0d want=%h/%b/%b lat=%0d",
                                    tag, d, bout, zero, cyc - e.issue, e.d, e.bout, e.zero, LAT);
                end
            end
            if (i == LAT) begin
                total++;
                if (out_valid !== 1'b1 || d !== ed || bout !== eb || zero !== ez) begin
                    bad++; $display("FAIL %s_const got v=%b d=%h bout=%b zero=%b want v=1 d=%h bout=%b zero=%b",
                                    tag, out_valid, d, bout, zero, ed, eb, ez);
                end
            end
        end
    endtask

    // 200 random operations streamed with ~30% bubbles.
    task automatic test_back_to_back();
        exp_t e;
        bit   exp_v;
        int   issued = 0;
        logic v;
        for (int i = 0; issued < 200 || i < issued + 300; i++) begin
            if (issued >= 200 && sb.size() == 0 && vq.size() <= LAT) break;
            v = (issued < 200) && ($urandom_range(0, 9) >= 3);
            if (v) issued++;
            drive(v, rnd128(), rnd128(), 1'($urandom_range(0, 1)));
            exp_v = (vq.size() > LAT) ? vq.pop_front() : 1'b0;
            total++;
            if (out_valid !== exp_v) begin
                bad++; $display("FAIL stream_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_v);
            end else if (exp_v) begin
                e = sb.pop_front();
                total++;
                if (d !== e.d || bout !== e.bout || zero !== e.zero || cyc - e.issue != LAT) begin
                    bad++; $display("FAIL stream_data cyc=%0d got=%h/%b/%b want=%h/%b/%b lat=%0d",
                                    cyc, d, bout, zero, e.d, e.bout, e.zero, cyc - e.issue);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL stream_drain left=%0d want=0", sb.size());
        end
    endtask

    // Reset with operations in flight: none may surface, and the next one has full latency.
    task automatic test_reset_mid();
        exp_t e;
        bit   exp_v;
        int   seen = 0;
        for (int i = 0; i < 5; i++) drive(1'b1, rnd128(), rnd128(), 1'($urandom_range(0, 1)));
        rst_n = 1'b0;
        drive(1'b1, rnd128(), rnd128(), 1'b1);
        total++;
        if (out_valid !== 1'b0 || d !== '0 || bout !== 1'b0 || zero !== 1'b0) begin
            bad++; $display("FAIL midreset_clear got v=%b d=%h bout=%b zero=%b want all 0", out_valid, d, bout, zero);
        end
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 4; i++) begin
            if (i == 0) drive(1'b1, 128'h10, 128'h3, 1'b0);
            else        drive(1'b0, rnd128(), rnd128(), 1'b0);
            exp_v = (vq.size() > LAT) ? vq.pop_front() : 1'b0;
            if (out_valid === 1'b1) seen++;
            total++;
            if (out_valid !== exp_v) begin
                bad++; $display("FAIL midreset_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_v);
            end else if (exp_v) begin
                e = sb.pop_front();
                total++;
                if (d !== 128'hD || bout !== 1'b0 || zero !== 1'b0 || cyc - e.issue != LAT) begin
                    bad++; $display("FAIL midreset_data got=%h/%b/%b lat=%0d want=d/0/0 lat=%0d",
                                    d, bout, zero, cyc - e.issue, LAT);
                end
            end
        end
        total++;
        if (seen != 1) begin
            bad++; $display("FAIL midreset_count got=%0d want=1", seen);
        end
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] k;
        ones     = {W{1'b1}};
        k        = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        bin      = 1'b0;

        test_reset();
        test_vector("simple", 128'd5, 128'd3, 1'b0, 128'd2, 1'b0, 1'b0);
        test_vector("full_borrow", 128'd0, 128'd1, 1'b0, ones, 1'b1, 1'b0);
        test_vector("msb", 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd1, 1'b0,
                    128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        test_vector("equal", k, k, 1'b0, '0, 1'b0, 1'b1);
        test_vector("equal_bin", k, k, 1'b1, ones, 1'b1, 1'b0);
        test_vector("seg_boundary", 128'h0000_0000_0000_0001_0000_0000_0000_0000, 128'd1, 1'b0,
                    128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        test_back_to_back();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
